// File: rtl/bless_router_param_pkg.sv
// Shared port numbering and small helpers for the BLESS deflection router.
package bless_router_param_pkg;

  localparam int NUM_NET  = 4;  // network ports N, E, S, W
  localparam int NUM_PORT = 5;  // network ports plus local
  localparam int NUM_SLOT = 5;  // four network flits plus one injected flit per cycle

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  // Lowest-index free network port; the caller guarantees at least one is free.
  function automatic logic [1:0] lowest_free(input logic [NUM_NET-1:0] free);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_NET - 1; i >= 0; i--) begin
      if (free[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bless_router_param_inj_fifo.sv
// Local injection FIFO: circular buffer, head visible combinationally so it can be popped on grant.
module bless_router_param_inj_fifo
#(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push_i,
  input  logic [DW-1:0]              push_data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // A push against a full FIFO is refused even if a pop happens the same cycle.
  assign push_ok = push_i && (count_q != FULL_CNT);
  assign pop_ok  = pop_i && (count_q != '0);

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and count; power-of-two depth makes pointer wrap implicit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/bless_router_param.sv
// Two-stage bufferless deflection mesh router with age priority, local injection and ejection.
module bless_router_param
  import bless_router_param_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int COORD_W      = 3,
  parameter int HOP_W        = 6,
  parameter int CORD_X       = 0,
  parameter int CORD_Y       = 0,
  parameter int INJ_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  input  logic [DATA_WIDTH-1:0] inj_data,
  input  logic                  inj_valid,
  output logic                  inj_ready,
  output logic [DATA_WIDTH-1:0] ej_data,
  output logic                  ej_valid,
  output logic                  starve
);
  // Header layout from the MSB down: vld, dst_y, dst_x, hop; payload below.
  localparam int VLD_POS   = DATA_WIDTH - 1;
  localparam int DST_Y_POS = VLD_POS - COORD_W;
  localparam int DST_X_POS = DST_Y_POS - COORD_W;
  localparam int HOP_POS   = DST_X_POS - HOP_W;
  localparam logic [COORD_W-1:0] OWN_X   = COORD_W'(CORD_X);
  localparam logic [COORD_W-1:0] OWN_Y   = COORD_W'(CORD_Y);
  localparam logic [HOP_W-1:0]   HOP_MAX = '1;
  localparam int CW = $clog2(INJ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] INJ_FULL   = CW'(INJ_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // XY routing: X first, then Y (Y grows southward); own coordinate means eject.
  function automatic port_e route(input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy);
    port_e p;
    if (dx > OWN_X)      p = PORT_E;
    else if (dx < OWN_X) p = PORT_W;
    else if (dy > OWN_Y) p = PORT_S;
    else if (dy < OWN_Y) p = PORT_N;
    else                 p = PORT_L;
    return p;
  endfunction

  function automatic logic [HOP_W-1:0] hop_inc(input logic [HOP_W-1:0] hop);
    return (hop == HOP_MAX) ? hop : hop + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] in_w       [NUM_NET];
  logic [DATA_WIDTH-1:0] in_q       [NUM_NET];
  logic [HOP_W:0]        key_w      [NUM_NET];
  logic [1:0]            rank_w     [NUM_NET];
  logic [DATA_WIDTH-1:0] srt_w      [NUM_NET];
  port_e                 srt_port_w [NUM_NET];
  logic [DATA_WIDTH-1:0] slot_q     [NUM_SLOT];
  port_e                 port_q     [NUM_SLOT];
  logic [DATA_WIDTH-1:0] out_d      [NUM_NET];
  logic [DATA_WIDTH-1:0] out_q      [NUM_NET];
  logic [DATA_WIDTH-1:0] inj_flit, fifo_head, ej_data_d, ej_data_q;
  port_e                 inj_port;
  logic                  ej_valid_d, ej_valid_q;
  logic                  fifo_empty, ej_any, all_valid, inj_grant;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  starve_q;

  assign in_w[0] = data_in_0;
  assign in_w[1] = data_in_1;
  assign in_w[2] = data_in_2;
  assign in_w[3] = data_in_3;

  generate
    for (genvar gi = 0; gi < NUM_NET; gi++) begin : g_net
      // Priority key: valid flits first, then older (higher hop) first.
      assign key_w[gi]      = {in_q[gi][VLD_POS], in_q[gi][HOP_POS +: HOP_W]};
      assign srt_port_w[gi] = route(srt_w[gi][DST_X_POS +: COORD_W], srt_w[gi][DST_Y_POS +: COORD_W]);
    end
  endgenerate

  // Rank each input by how many others beat it; ties go to the lower input index.
  always_comb begin
    for (int i = 0; i < NUM_NET; i++) begin
      rank_w[i] = 2'd0;
      for (int j = 0; j < NUM_NET; j++) begin
        if ((key_w[j] > key_w[i]) || ((key_w[j] == key_w[i]) && (j < i)))
          rank_w[i] = rank_w[i] + 2'd1;
      end
    end
  end

  // Place each input in its rank slot; ranks are distinct so the OR acts as a mux.
  always_comb begin
    for (int s = 0; s < NUM_NET; s++) begin
      srt_w[s] = '0;
      for (int i = 0; i < NUM_NET; i++) begin
        if (rank_w[i] == 2'(s)) srt_w[s] = srt_w[s] | in_q[i];
      end
    end
  end

  // Injection is allowed only when a network output is guaranteed to remain free.
  always_comb begin
    ej_any    = 1'b0;
    all_valid = 1'b1;
    for (int i = 0; i < NUM_NET; i++) begin
      if (srt_w[i][VLD_POS] && (srt_port_w[i] == PORT_L)) ej_any = 1'b1;
      if (!srt_w[i][VLD_POS]) all_valid = 1'b0;
    end
    inj_grant = !fifo_empty && !(all_valid && !ej_any);
    inj_flit  = fifo_head;
    inj_flit[VLD_POS] = 1'b1;
    inj_flit[HOP_POS +: HOP_W] = '0;
  end

  assign inj_port = route(inj_flit[DST_X_POS +: COORD_W], inj_flit[DST_Y_POS +: COORD_W]);

  // Input registers and the sorted ST1 stage; the injected flit always occupies the last slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_NET; i++) in_q[i] <= '0;
      for (int s = 0; s < NUM_SLOT; s++) begin
        slot_q[s] <= '0;
        port_q[s] <= PORT_N;
      end
    end else begin
      for (int i = 0; i < NUM_NET; i++) begin
        in_q[i]   <= in_w[i];
        slot_q[i] <= srt_w[i];
        port_q[i] <= srt_port_w[i];
      end
      slot_q[NUM_SLOT-1] <= inj_grant ? inj_flit : '0;
      port_q[NUM_SLOT-1] <= inj_port;
    end
  end

  // Allocate in rank order: one ejection, productive port if free, else lowest free port.
  always_comb begin
    logic [NUM_NET-1:0] free;
    logic               ej_taken;
    logic [1:0]         p;
    free       = '1;
    ej_taken   = 1'b0;
    p          = 2'd0;
    ej_data_d  = '0;
    ej_valid_d = 1'b0;
    for (int k = 0; k < NUM_NET; k++) out_d[k] = '0;
    for (int s = 0; s < NUM_SLOT; s++) begin
      if (slot_q[s][VLD_POS]) begin
        if ((port_q[s] == PORT_L) && !ej_taken) begin
          ej_taken   = 1'b1;
          ej_data_d  = slot_q[s];
          ej_valid_d = 1'b1;
        end else begin
          if ((port_q[s] != PORT_L) && free[port_q[s][1:0]]) p = port_q[s][1:0];
          else p = lowest_free(free);
          free[p]  = 1'b0;
          out_d[p] = slot_q[s];
          out_d[p][HOP_POS +: HOP_W] = hop_inc(slot_q[s][HOP_POS +: HOP_W]);
        end
      end
    end
  end

  // Starvation counter: counts blocked cycles with a queued flit, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || inj_grant) starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Output registers, ejection port and starvation state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_NET; k++) out_q[k] <= '0;
      ej_data_q    <= '0;
      ej_valid_q   <= 1'b0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_NET; k++) out_q[k] <= out_d[k];
      ej_data_q    <= ej_data_d;
      ej_valid_q   <= ej_valid_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= (starve_cnt_d == STARVE_MAX);
    end
  end

  bless_router_param_inj_fifo #(
    .DEPTH (INJ_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_inj_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .push_i      (inj_valid),
    .push_data_i (inj_data),
    .pop_i       (inj_grant),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign inj_ready  = (fifo_count < INJ_FULL);
  assign data_out_0 = out_q[0];
  assign data_out_1 = out_q[1];
  assign data_out_2 = out_q[2];
  assign data_out_3 = out_q[3];
  assign ej_data    = ej_data_q;
  assign ej_valid   = ej_valid_q;
  assign starve     = starve_q;

endmodule
